// File: rtl/fsm_3.sv
// Three-state Moore FSM (IDLE/S0/S1) steered by a serial din bit; din=1 toggles S0<->S1.
// Optional S1-entry counter on toggle_cnt is enabled by defining FSM_3_TOGGLE_CNT_EN.
module fsm_3
`ifdef FSM_3_TOGGLE_CNT_EN
#(
    parameter int unsigned CNT_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             dout,
    output logic [1:0]       p_state,
    output logic [1:0]       n_state
`ifdef FSM_3_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_S0   = 2'b01,
        ST_S1   = 2'b10,
        ST_ILL  = 2'b11
    } state_e;

    // State is held as plain bits so the illegal code 2'b11 is representable.
    logic [1:0] p_state_q, p_state_d;
    logic [1:0] n_state_d;
    logic       dout_q, dout_d;

    // Next-state decode; ignores rst so n_state always reflects the transition rules.
    always_comb begin
        n_state_d = ST_IDLE;
        case (p_state_q)
            ST_IDLE: n_state_d = ST_S0;
            ST_S0:   n_state_d = din ? ST_S1 : ST_S0;
            ST_S1:   n_state_d = din ? ST_S0 : ST_S1;
            default: n_state_d = ST_IDLE;
        endcase
    end

    // Register inputs; dout is decoded from the state about to be loaded so it tracks p_state.
    always_comb begin
        p_state_d = rst ? ST_IDLE : n_state_d;
        dout_d    = (p_state_d == ST_S1);
    end

    always_ff @(posedge clk) begin
        p_state_q <= p_state_d;
        dout_q    <= dout_d;
    end

`ifdef FSM_3_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count S0->S1 transitions, wrapping naturally at the counter width.
    always_comb begin
        cnt_d = cnt_q;
        if (rst) begin
            cnt_d = '0;
        end else if (p_state_q == ST_S0 && n_state_d == ST_S1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign toggle_cnt = cnt_q;
`endif

    assign p_state = p_state_q;
    assign n_state = n_state_d;
    assign dout    = dout_q;

endmodule

// File: tb/tb_fsm_3.sv
// Self-checking bench for fsm_3: directed steps then random din/rst against a behavioural model.
// Build with FSM_3_TOGGLE_CNT_EN defined to also check the 2-bit toggle counter.
module tb_fsm_3;

    localparam int unsigned TB_CNT_W = 2;
    localparam int M_IDLE = 0;
    localparam int M_S0   = 1;
    localparam int M_S1   = 2;
    localparam int M_ILL  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       dout;
    logic [1:0] p_state;
    logic [1:0] n_state;
`ifdef FSM_3_TOGGLE_CNT_EN
    logic [TB_CNT_W-1:0] toggle_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int ms;        // model state
    int mcnt;      // model S1-entry count

`ifdef FSM_3_TOGGLE_CNT_EN
    fsm_3 #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout),
        .p_state(p_state), .n_state(n_state), .toggle_cnt(toggle_cnt)
    );
`else
    fsm_3 dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout),
        .p_state(p_state), .n_state(n_state)
    );
`endif

    always #5 clk = ~clk;

    function automatic int model_next(input int s, input bit d);
        if (s == M_IDLE) return M_S0;
        if (s == M_ILL)  return M_IDLE;
        if (d)           return (s == M_S0) ? M_S1 : M_S0;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check n_state, take the edge, check registered outputs.
    task automatic step(input bit d, input bit r, input bit chk_n);
        int prev;
        @(negedge clk);
        din = d;
        rst = r;
        #1;
        if (chk_n) chk("n_state", 8'(n_state), 8'(model_next(ms, d)));
        @(posedge clk);
        #1;
        prev = ms;
        ms = r ? M_IDLE : model_next(ms, d);
        if (r) mcnt = 0;
        else if (prev == M_S0 && ms == M_S1) mcnt = (mcnt + 1) % (1 << TB_CNT_W);
        chk("p_state", 8'(p_state), 8'(ms));
        chk("dout", 8'(dout), 8'(ms == M_S1));
`ifdef FSM_3_TOGGLE_CNT_EN
        chk("toggle_cnt", 8'(toggle_cnt), 8'(mcnt));
`endif
    endtask

    initial begin
        rst  = 1'b1;
        din  = 1'b1;
        ms   = M_IDLE;
        mcnt = 0;

        // Reset held two edges with din=1; first edge state is unknown beforehand.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_n_state", 8'(n_state), 8'(2'b01));

        // Release with din=0: IDLE->S0, then hold S0.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

        // din=1 held six edges from S0: square wave.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);

        // Reach S1, hold with din=0, then toggle back.
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // Illegal encoding recovers to IDLE on the next edge.
        force dut.p_state_q = 2'b11;
        #1;
        chk("illegal_n_state", 8'(n_state), 8'(2'b00));
        release dut.p_state_q;
        ms = M_ILL;
        step(1'b1, 1'b0, 1'b1);
        chk("illegal_recover", 8'(p_state), 8'(2'b00));

        // Counter wrap run from S0, then reset mid-toggle.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // Random din with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), ($urandom_range(0, 15) == 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
